// File: rtl/bkm_iter_ctrl_pkg.sv
// Shared constants for the BKM iteration sequencer: FSM encodings and digit codes.
package bkm_iter_ctrl_pkg;

  // FSM state encodings
  localparam logic [1:0] BKM_ST_IDLE = 2'd0;
  localparam logic [1:0] BKM_ST_ITER = 2'd1;
  localparam logic [1:0] BKM_ST_DONE = 2'd2;

  // One's-complement digit codes; 2'b11 is a redundant zero
  localparam logic [1:0] BKM_D_ZERO = 2'b00;
  localparam logic [1:0] BKM_D_POS  = 2'b01;
  localparam logic [1:0] BKM_D_NEG  = 2'b10;

  // Fold the redundant zero code onto BKM_D_ZERO
  function automatic logic [1:0] canon_digit(input logic [1:0] d);
    return (d == 2'b11) ? BKM_D_ZERO : d;
  endfunction

endpackage

// File: rtl/bkm_iter_ctrl_if.sv
// Operand, digit-selector and result signals of the BKM iteration sequencer.
interface bkm_iter_ctrl_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned NW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x0;
  logic [W-1:0]  y0;
  logic [NW-1:0] n_iter;
  logic [NW-1:0] step_n;
  logic [W-1:0]  z_x;
  logic [W-1:0]  z_y;
  logic [1:0]    sel_d_x;
  logic [1:0]    sel_d_y;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  x_out;
  logic [W-1:0]  y_out;
  logic          busy;

  // Sequencer side
  modport slave (
    input  in_valid, x0, y0, n_iter, sel_d_x, sel_d_y, out_ready,
    output in_ready, step_n, z_x, z_y, out_valid, x_out, y_out, busy
  );

  // Producer / selector / consumer side
  modport master (
    output in_valid, x0, y0, n_iter, sel_d_x, sel_d_y, out_ready,
    input  in_ready, step_n, z_x, z_y, out_valid, x_out, y_out, busy
  );
endinterface

// File: rtl/bkm_iter_ctrl_multiply_by_d.sv
// Complex product p = d * z for digits d_x, d_y in {-1, 0, +1}; W-bit wrapping result.
module multiply_by_d
  import bkm_iter_ctrl_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [1:0]   d_x,
  input  logic [1:0]   d_y,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] p_x,
  output logic [W-1:0] p_y
);

  // Multiply a value by a single canonical digit
  function automatic logic [W-1:0] scale(input logic [1:0] d, input logic [W-1:0] v);
    case (d)
      BKM_D_POS: return v;
      BKM_D_NEG: return -v;
      default:   return '0;
    endcase
  endfunction

  // (dx + j*dy) * (x + j*y) = (dx*x - dy*y) + j*(dx*y + dy*x)
  always_comb begin
    p_x = scale(d_x, x) - scale(d_y, y);
    p_y = scale(d_x, y) + scale(d_y, x);
  end

endmodule

// File: rtl/bkm_iter_ctrl.sv
// Sequencer for the BKM complex iteration z[n+1] = z[n] + d[n]*z[n]*2^-n.
module bkm_iter_ctrl
  import bkm_iter_ctrl_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned NW = 4
) (
  input logic            clk,
  input logic            arst_n,
  bkm_iter_ctrl_if.slave bus
);

  logic [1:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] niter_q, niter_d;
  logic [W-1:0]  zx_q, zx_d;
  logic [W-1:0]  zy_q, zy_d;
  logic [W-1:0]  xo_q, xo_d;
  logic [W-1:0]  yo_q, yo_d;

  logic [1:0]         dx, dy;
  logic [W-1:0]       px, py;
  logic signed [W-1:0] shx, shy;
  logic [W-1:0]       zx_sum, zy_sum;

  assign dx = canon_digit(bus.sel_d_x);
  assign dy = canon_digit(bus.sel_d_y);

  multiply_by_d #(.W(W)) u_mul (
    .d_x (dx),
    .d_y (dy),
    .x   (zx_q),
    .y   (zy_q),
    .p_x (px),
    .p_y (py)
  );

  // Arithmetic shift by n; shifts of W or more fill with the sign bit
  always_comb begin
    shx    = $signed(px) >>> n_q;
    shy    = $signed(py) >>> n_q;
    zx_sum = zx_q + shx;
    zy_sum = zy_q + shy;
  end

  // Next-state logic: operand latch, iteration update and result capture
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    niter_d = niter_q;
    zx_d    = zx_q;
    zy_d    = zy_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    case (state_q)
      BKM_ST_IDLE: begin
        if (bus.in_valid) begin
          zx_d    = bus.x0;
          zy_d    = bus.y0;
          n_d     = '0;
          niter_d = bus.n_iter;
          if (bus.n_iter == '0) begin
            state_d = BKM_ST_DONE;
            xo_d    = bus.x0;
            yo_d    = bus.y0;
          end else begin
            state_d = BKM_ST_ITER;
          end
        end
      end
      BKM_ST_ITER: begin
        zx_d = zx_sum;
        zy_d = zy_sum;
        n_d  = n_q + NW'(1);
        if (n_q == niter_q - NW'(1)) begin
          state_d = BKM_ST_DONE;
          xo_d    = zx_sum;
          yo_d    = zy_sum;
        end
      end
      BKM_ST_DONE: begin
        if (bus.out_ready) state_d = BKM_ST_IDLE;
      end
      default: state_d = BKM_ST_IDLE;
    endcase
  end

  // State registers; reset discards any partial result
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= BKM_ST_IDLE;
      n_q     <= '0;
      niter_q <= '0;
      zx_q    <= '0;
      zy_q    <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      niter_q <= niter_d;
      zx_q    <= zx_d;
      zy_q    <= zy_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
    end
  end

  // Output decode
  always_comb begin
    bus.in_ready  = (state_q == BKM_ST_IDLE);
    bus.out_valid = (state_q == BKM_ST_DONE);
    bus.busy      = (state_q != BKM_ST_IDLE);
    bus.step_n    = n_q;
    bus.z_x       = zx_q;
    bus.z_y       = zy_q;
    bus.x_out     = xo_q;
    bus.y_out     = yo_q;
  end

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Self-checking bench for bkm_iter_ctrl: directed cases plus randomized operands and digits.
module tb_bkm_iter_ctrl;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  bkm_iter_ctrl_if #(.W(16), .NW(4)) bus ();

  bkm_iter_ctrl #(.W(16), .NW(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Combinational digit selector: digit tables indexed by the exposed step
  logic [1:0] dig_x [16];
  logic [1:0] dig_y [16];
  assign bus.sel_d_x = dig_x[bus.step_n];
  assign bus.sel_d_y = dig_y[bus.step_n];

  int vectors = 0;
  int miscompares = 0;

  // Expected values for the cycle in progress
  logic chk_en = 1'b0;
  logic e_in_ready, e_out_valid, e_busy, e_z_chk;
  int   e_step, e_zx, e_zy, e_xo, e_yo;
  int   last_x = 0, last_y = 0, last_n = 0;

  // Model trace of z over the iterations
  int tx [17];
  int ty [17];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx16(input int v);
    shortint t;
    t = shortint'(v);
    return int'(t);
  endfunction

  function automatic int dval(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return -1;
    return 0;
  endfunction

  function automatic int ashr(input int v, input int n);
    if (n >= 16) return (v < 0) ? -1 : 0;
    return v >>> n;
  endfunction

  // Reference: z[k+1] = z[k] + (d[k]*z[k] wrapped to 16 bits) >>> k, wrapped to 16 bits
  task automatic build_trace(input int x, input int y, input int ni);
    int dx, dy, px, py;
    tx[0] = sx16(x);
    ty[0] = sx16(y);
    for (int k = 0; k < ni; k++) begin
      dx = dval(dig_x[k]);
      dy = dval(dig_y[k]);
      px = sx16(dx * tx[k] - dy * ty[k]);
      py = sx16(dx * ty[k] + dy * tx[k]);
      tx[k+1] = sx16(tx[k] + ashr(px, k));
      ty[k+1] = sx16(ty[k] + ashr(py, k));
    end
  endtask

  // Single compare process, active every cycle once enabled
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(bus.in_ready), int'(e_in_ready));
      chk("out_valid", int'(bus.out_valid), int'(e_out_valid));
      chk("busy", int'(bus.busy), int'(e_busy));
      chk("step_n", int'(bus.step_n), e_step & 'hF);
      chk("x_out", int'(bus.x_out), e_xo & 'hFFFF);
      chk("y_out", int'(bus.y_out), e_yo & 'hFFFF);
      if (e_z_chk) begin
        chk("z_x", int'(bus.z_x), e_zx & 'hFFFF);
        chk("z_y", int'(bus.z_y), e_zy & 'hFFFF);
      end
    end
  end

  task automatic set_idle();
    e_in_ready = 1'b1; e_out_valid = 1'b0; e_busy = 1'b0; e_z_chk = 1'b0;
    e_step = last_n; e_xo = last_x; e_yo = last_y;
  endtask

  task automatic set_reset_exp();
    last_x = 0; last_y = 0; last_n = 0;
    set_idle();
  endtask

  // One operand: accept, iterate, hold result for `hold` cycles, optionally reset at step abort_at
  task automatic run_op(input int x, input int y, input int ni, input int hold,
                        input int abort_at, input bit hold_valid);
    build_trace(x, y, ni);
    bus.x0 = x[15:0]; bus.y0 = y[15:0]; bus.n_iter = ni[3:0]; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = hold_valid;
    if (hold_valid) begin
      bus.x0 = 16'($urandom); bus.y0 = 16'($urandom); bus.n_iter = 4'($urandom);
    end
    for (int k = 0; k < ni; k++) begin
      e_in_ready = 1'b0; e_out_valid = 1'b0; e_busy = 1'b1; e_z_chk = 1'b1;
      e_step = k; e_zx = tx[k]; e_zy = ty[k];
      if (k == abort_at) begin
        arst_n = 1'b0;
        bus.in_valid = 1'b0;
        set_reset_exp();
        @(negedge clk); #2;
        arst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    e_in_ready = 1'b0; e_out_valid = 1'b1; e_busy = 1'b1; e_z_chk = 1'b1;
    e_step = ni; e_zx = tx[ni]; e_zy = ty[ni]; e_xo = tx[ni]; e_yo = ty[ni];
    bus.out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    last_x = tx[ni]; last_y = ty[ni]; last_n = ni;
    set_idle();
  endtask

  initial begin
    int ni, ab;
    for (int i = 0; i < 16; i++) begin
      dig_x[i] = 2'b00; dig_y[i] = 2'b00;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.n_iter = '0;
    set_reset_exp();

    // Reset, then reassert in the middle of a clock phase
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    @(posedge clk); #3;
    arst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_x_out", int'(bus.x_out), 0);
    chk("rst_y_out", int'(bus.y_out), 0);
    @(negedge clk); #2 arst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Single step, d = +1
    dig_x[0] = 2'b01; dig_y[0] = 2'b00;
    run_op('h1000, 0, 1, 0, -1, 1'b0);
    chk("t2_model_x", tx[1] & 'hFFFF, 'h2000);
    chk("t2_x_out", int'(bus.x_out), 'h2000);
    chk("t2_y_out", int'(bus.y_out), 'h0000);

    // Imaginary digit at n = 1
    dig_x[0] = 2'b00; dig_y[0] = 2'b00; dig_x[1] = 2'b00; dig_y[1] = 2'b01;
    run_op('h1000, 0, 2, 0, -1, 1'b0);
    chk("t3_x_out", int'(bus.x_out), 'h1000);
    chk("t3_y_out", int'(bus.y_out), 'h0800);

    // d = 1 + j on both steps, with backpressure and in_valid held
    dig_x[0] = 2'b01; dig_y[0] = 2'b01; dig_x[1] = 2'b01; dig_y[1] = 2'b01;
    run_op('h0400, 0, 2, 5, -1, 1'b1);
    chk("t4_model_x1", tx[1] & 'hFFFF, 'h0800);
    chk("t4_model_y1", ty[1] & 'hFFFF, 'h0400);
    chk("t4_x_out", int'(bus.x_out), 'h0A00);
    chk("t4_y_out", int'(bus.y_out), 'h0A00);

    // Zero iterations pass the operand straight through
    run_op('h1234, 0, 0, 1, -1, 1'b0);
    chk("t6_x_out", int'(bus.x_out), 'h1234);

    // Reset during iteration at step 1
    dig_x[0] = 2'b01; dig_y[0] = 2'b10; dig_x[1] = 2'b01; dig_y[1] = 2'b00;
    run_op('h0777, 'h0123, 3, 0, 1, 1'b0);
    chk("t6_abort_x_out", int'(bus.x_out), 0);
    chk("t6_abort_out_valid", int'(bus.out_valid), 0);

    // Redundant zero digit leaves z unchanged
    dig_x[0] = 2'b11; dig_y[0] = 2'b11; dig_x[1] = 2'b11; dig_y[1] = 2'b11;
    run_op('h1000, 0, 2, 0, -1, 1'b0);
    chk("t6_d11_x_out", int'(bus.x_out), 'h1000);
    chk("t6_d11_y_out", int'(bus.y_out), 'h0000);

    // Randomized operands, digits, lengths, backpressure and occasional resets
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 16; i++) begin
        dig_x[i] = 2'($urandom); dig_y[i] = 2'($urandom);
      end
      ni = $urandom_range(0, 15);
      ab = -1;
      if (ni > 0 && $urandom_range(0, 9) == 0) ab = $urandom_range(0, ni - 1);
      run_op(int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 'hFFFF)), ni,
             $urandom_range(0, 3), ab, 1'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
